// File: rtl/seg7_display_ctrl_pkg.sv
// Shared types and constants for the 7-segment display controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE,
    DONE
  } ctrl_state_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Largest value representable on num_digits decimal digits.
  function automatic int max_bcd_val(input int num_digits);
    int r;
    r = 1;
    for (int i = 0; i < num_digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Request/result bundle between game logic and the display controller.
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic                    start;
  logic [BIN_W-1:0]        value;
  logic                    blank_lz;
  logic                    ready;
  logic                    done;
  logic                    ovf;
  logic [7*NUM_DIGITS-1:0] leds;

  modport master (
    output start, value, blank_lz,
    input  ready, done, ovf, leds
  );

  modport slave (
    input  start, value, blank_lz,
    output ready, done, ovf, leds
  );
endinterface

// File: rtl/seg7_display_ctrl_seg7.sv
// Hex-nibble to active-low 7-segment decoder; codes above 9 show a dash.
module seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Decimal digit lookup.
  always_comb begin
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Binary-to-BCD display sequencer: captures a value, converts it with a
// serial double-dabble engine, decodes one digit per cycle through a shared
// seg7 instance and updates the whole HEX image at once.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                clk,
  input  logic                reset,
  seg7_display_ctrl_if.slave  bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL    = BIN_W'(max_bcd_val(NUM_DIGITS));
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(NUM_DIGITS - 1);

  ctrl_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q, bcd_adj;
  logic             blank_lz_q;
  logic             ovf_pend;
  logic [SEG_W-1:0] staging, staging_nx;
  logic [3:0]       nibble;
  logic [6:0]       seg_raw, seg_code;
  logic             lz_blank;

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE:    if (bus.start)         state_nx = CONVERT;
      CONVERT: if (cnt == CONV_LAST)  state_nx = WRITE;
      WRITE:   if (cnt == WRITE_LAST) state_nx = DONE;
      DONE:                           state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Add-3 correction, digit selection and leading-zero blanking.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    nibble     = bcd_q[4*cnt +: 4];
    lz_blank   = blank_lz_q && (cnt != '0) && ((bcd_q >> (4*cnt)) == '0);
    seg_code   = lz_blank ? SEG_BLANK : seg_raw;
    staging_nx = staging;
    staging_nx[7*cnt +: 7] = seg_code;
  end

  seg7 u_seg7 (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Capture, conversion, staging and commit datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      blank_lz_q <= 1'b0;
      ovf_pend   <= 1'b0;
      // NOTE: staging is a handful of flops, not a RAM, so it is cleared on
      // reset like any other state.
      staging    <= '0;
      bus.leds   <= {NUM_DIGITS{SEG_BLANK}};
      bus.ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.start) begin
            bcd_q      <= '0;
            blank_lz_q <= bus.blank_lz;
            if (bus.value > MAX_VAL) begin
              bin_q    <= MAX_VAL;
              ovf_pend <= 1'b1;
            end else begin
              bin_q    <= bus.value;
              ovf_pend <= 1'b0;
            end
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt <= (cnt == CONV_LAST) ? '0 : cnt + 1'b1;
        end
        WRITE: begin
          staging <= staging_nx;
          cnt     <= cnt + 1'b1;
          // The full image is loaded on the edge that enters DONE, so the new
          // leds/ovf appear in exactly the cycle that done is high.
          if (cnt == WRITE_LAST) begin
            bus.leds <= staging_nx;
            bus.ovf  <= ovf_pend;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Clamped BCD digits are always decimal.
  a_nibble_decimal: assert property (
    @(posedge clk) disable iff (reset) (state == WRITE) |-> (nibble <= 4'd9)
  );

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: vector table plus directed
// sequences for ignored starts, back-to-back requests and mid-run reset.
module tb_seg7_display_ctrl;

  localparam int ND  = 4;
  localparam int BW  = 14;
  localparam int LAT = BW + ND + 1;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                         D9 = 7'b0010000, BL = 7'b1111111;

  typedef struct {
    logic [BW-1:0]   value;
    logic            blz;
    logic [7*ND-1:0] leds;
    logic            ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[11];

  always #5 clk = ~clk;

  seg7_display_ctrl_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus ();

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request starting in the next cycle; waits for done and checks it.
  task automatic run_conv(input logic [BW-1:0] v, input logic blz, input string tag,
                          input logic [7*ND-1:0] exp_leds, input logic exp_ovf);
    logic [7*ND-1:0] leds_before;
    logic            ovf_before;
    int              lat;
    bit              stable;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(bus.ready), 32'd1);
    leds_before  = bus.leds;
    ovf_before   = bus.ovf;
    bus.start    = 1'b1;
    bus.value    = v;
    bus.blank_lz = blz;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.value    = ~v;
    bus.blank_lz = ~blz;
    lat    = -1;
    stable = 1'b1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, " ready_busy"}, 32'(bus.ready), 32'd0);
      if (bus.done) lat = n;
      else if (bus.leds !== leds_before || bus.ovf !== ovf_before) stable = 1'b0;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " leds"}, 32'(bus.leds), 32'(exp_leds));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, " hold"}, 32'(stable), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, lat2, dones;
    bit  saw_done;

    vecs[0]  = '{14'd1234,  1'b0, {D1, D2, D3, D4}, 1'b0};
    vecs[1]  = '{14'd7,     1'b1, {BL, BL, BL, D7}, 1'b0};
    vecs[2]  = '{14'd0,     1'b1, {BL, BL, BL, D0}, 1'b0};
    vecs[3]  = '{14'd305,   1'b1, {BL, D3, D0, D5}, 1'b0};
    vecs[4]  = '{14'd12000, 1'b0, {D9, D9, D9, D9}, 1'b1};
    vecs[5]  = '{14'd42,    1'b0, {D0, D0, D4, D2}, 1'b0};
    vecs[6]  = '{14'd9999,  1'b1, {D9, D9, D9, D9}, 1'b0};
    vecs[7]  = '{14'd10000, 1'b1, {D9, D9, D9, D9}, 1'b1};
    vecs[8]  = '{14'd0,     1'b0, {D0, D0, D0, D0}, 1'b0};
    vecs[9]  = '{14'd1000,  1'b1, {D1, D0, D0, D0}, 1'b0};
    vecs[10] = '{14'd16383, 1'b0, {D9, D9, D9, D9}, 1'b1};

    // Reset held 3 cycles with start high.
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.value    = 14'd1234;
    bus.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst leds", 32'(bus.leds), 32'({BL, BL, BL, BL}));
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst ovf", 32'(bus.ovf), 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst start ignored", 32'(bus.ready), 32'd1);

    // Table of requests, issued back-to-back.
    for (int i = 0; i < 11; i++)
      run_conv(vecs[i].value, vecs[i].blz, $sformatf("vec%0d", i), vecs[i].leds, vecs[i].ovf);

    // Starts while busy and in the DONE cycle are ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.value = 14'd1234; bus.blank_lz = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; dones = 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n; dones++;
        bus.start = 1'b1; bus.value = 14'd5678;
      end else begin
        bus.start = (n == 3);
        bus.value = 14'd5678;
      end
    end
    check("ign latency", 32'(lat), 32'(LAT));
    check("ign leds", 32'(bus.leds), 32'({D1, D2, D3, D4}));
    check("ign dones", 32'(dones), 32'd1);
    @(negedge clk);
    check("b2b ready", 32'(bus.ready), 32'd1);
    check("b2b done low", 32'(bus.done), 32'd0);
    check("b2b leds hold", 32'(bus.leds), 32'({D1, D2, D3, D4}));
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat2 = -1;
    for (int n = 1; n <= 40 && lat2 < 0; n++) begin
      @(negedge clk);
      if (bus.done) lat2 = n;
    end
    check("b2b latency", 32'(lat2), 32'(LAT));
    check("b2b leds", 32'(bus.leds), 32'({D5, D6, D7, D8}));
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("no queued start", 32'(saw_done), 32'd0);

    // Mid-conversion reset aborts, with ovf set beforehand.
    run_conv(14'd12000, 1'b0, "pre_rst", {D9, D9, D9, D9}, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.value = 14'd1234; bus.blank_lz = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort leds", 32'(bus.leds), 32'({BL, BL, BL, BL}));
    check("abort ready", 32'(bus.ready), 32'd1);
    check("abort ovf", 32'(bus.ovf), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    run_conv(14'd9, 1'b0, "post_rst", {D0, D0, D0, D9}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
